// File: rtl/exec_dispatch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : dispatch_pkg                                               |
// | Brief   : Instruction field offsets, opcode classes and index types  |
// |           shared by the dispatcher and its GPR scoreboard.           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package dispatch_pkg;

  // Register-index field positions inside an instruction word
  localparam int DST_LSB     = 4;
  localparam int SRCA_LSB    = 8;
  localparam int SRCB_LSB    = 12;
  localparam int REG_FIELD_W = 4;

  // Opcode classes carried in the low bits of an instruction
  localparam logic [2:0] OPC_ALU  = 3'b100;
  localparam logic [2:0] OPC_PFCU = 3'b110;
  localparam logic [2:0] OPC_LSU  = 3'b010;

  // Unit ids are wide enough for up to 16 execution units
  localparam int UNIT_ID_W = 4;

  typedef logic [UNIT_ID_W-1:0]   unit_id_t;
  typedef logic [REG_FIELD_W-1:0] reg_idx_t;

endpackage
`default_nettype wire

// File: rtl/exec_dispatch_unit_gpr_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gpr_scoreboard                                             |
// | Brief   : Per-register pending/owner tracking, hazard lookup and the |
// |           ownership-based GPR write-port mux.                        |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module gpr_scoreboard
  import dispatch_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int NUM_GPR = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         claim_en,
  input  reg_idx_t                     claim_reg,
  input  unit_id_t                     claim_unit,
  input  logic [N_UNITS-1:0]           release_mask,
  input  reg_idx_t                     qry_a,
  input  reg_idx_t                     qry_b,
  input  reg_idx_t                     qry_d,
  output logic                         a_pend,
  output logic                         b_pend,
  output logic                         d_pend,
  input  logic [N_UNITS*NUM_GPR-1:0]    u_gpr_we,
  input  logic [N_UNITS*NUM_GPR*32-1:0] u_gpr_dat,
  output logic [NUM_GPR-1:0]           gpr_we,
  output logic [NUM_GPR*32-1:0]        gpr_dat
);

  logic [NUM_GPR-1:0]      r_pending;
  unit_id_t                r_owner [NUM_GPR];
  logic [NUM_GPR-1:0]      w_release;
  logic [NUM_GPR-1:0]      w_sel_we;
  logic [NUM_GPR*32-1:0]   w_sel_dat;

  assign a_pend = r_pending[qry_a];
  assign b_pend = r_pending[qry_b];
  assign d_pend = r_pending[qry_d];

  // A register is released when the unit that owns it completes
  always_comb begin
    w_release = '0;
    for (int r = 0; r < NUM_GPR; r++) begin
      for (int u = 0; u < N_UNITS; u++) begin
        if (release_mask[u] && (r_owner[r] == unit_id_t'(u))) begin
          w_release[r] = 1'b1;
        end
      end
    end
  end

  // Claim has priority over a release landing on the same register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      for (int r = 0; r < NUM_GPR; r++) begin
        r_owner[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_GPR; r++) begin
        if (claim_en && (claim_reg == reg_idx_t'(r))) begin
          r_pending[r] <= 1'b1;
          r_owner[r]   <= claim_unit;
        end else if (w_release[r]) begin
          r_pending[r] <= 1'b0;
        end
      end
    end
  end

  // Route each register's write port from its current owner only
  always_comb begin
    w_sel_we  = '0;
    w_sel_dat = '0;
    for (int r = 0; r < NUM_GPR; r++) begin
      for (int u = 0; u < N_UNITS; u++) begin
        if (r_owner[r] == unit_id_t'(u)) begin
          w_sel_we[r]            = u_gpr_we[u*NUM_GPR + r];
          w_sel_dat[r*32 +: 32]  = u_gpr_dat[(u*NUM_GPR + r)*32 +: 32];
        end
      end
    end
  end

  // Unowned registers drop writes; data is zero whenever no write is forwarded
  always_comb begin
    gpr_we  = r_pending & w_sel_we & {NUM_GPR{~rst}};
    gpr_dat = '0;
    for (int r = 0; r < NUM_GPR; r++) begin
      if (gpr_we[r]) begin
        gpr_dat[r*32 +: 32] = w_sel_dat[r*32 +: 32];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/exec_dispatch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : exec_dispatch_unit                                         |
// | Brief   : In-order dispatcher from the instruction queue to several  |
// |           concurrently running execution units, with GPR hazard      |
// |           checking and serialisation of program-flow instructions.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module exec_dispatch_unit
  import dispatch_pkg::*;
#(
  parameter int                          N_UNITS    = 4,
  parameter int                          INSTR_W    = 32,
  parameter int                          OPC_BITS   = 3,
  parameter int                          NUM_GPR    = 16,
  parameter logic [N_UNITS*OPC_BITS-1:0] UNIT_OPC   = {3'b001, OPC_LSU, OPC_PFCU, OPC_ALU},
  parameter logic [N_UNITS-1:0]          WRITES_DST = 4'b0101,
  parameter logic [N_UNITS-1:0]          USES_SRC   = 4'b0101,
  parameter logic [N_UNITS-1:0]          SERIAL     = 4'b0010
) (
  input  logic                          cclk,
  input  logic                          rst,
  input  logic                          iq_ip,
  input  logic [INSTR_W-1:0]            iq_dat,
  output logic                          iq_pop,
  output logic [N_UNITS-1:0]            u_en,
  output logic [N_UNITS*INSTR_W-1:0]    u_ins,
  input  logic [N_UNITS-1:0]            u_dn,
  input  logic [N_UNITS*NUM_GPR-1:0]     u_gpr_we,
  input  logic [N_UNITS*NUM_GPR*32-1:0]  u_gpr_dat,
  output logic [NUM_GPR-1:0]            gpr_we,
  output logic [NUM_GPR*32-1:0]         gpr_dat,
  output logic                          illegal,
  output logic                          busy,
  output logic [31:0]                   issue_cnt,
  output logic [31:0]                   stall_cnt
);

  logic [N_UNITS-1:0]         r_busy;
  logic [N_UNITS*INSTR_W-1:0] r_u_ins;
  logic [31:0]                r_issue_cnt;
  logic [31:0]                r_stall_cnt;

  logic [OPC_BITS-1:0]        w_opc;
  reg_idx_t                   w_dst;
  reg_idx_t                   w_srca;
  reg_idx_t                   w_srcb;
  logic [N_UNITS-1:0]         w_tgt_oh;
  unit_id_t                   w_tgt_id;
  logic                       w_hit;
  logic                       w_tgt_busy;
  logic                       w_tgt_serial;
  logic                       w_tgt_uses;
  logic                       w_tgt_writes;
  logic                       w_any_busy;
  logic                       w_serial_busy;
  logic                       w_a_pend;
  logic                       w_b_pend;
  logic                       w_d_pend;
  logic                       w_src_hazard;
  logic                       w_dst_hazard;
  logic                       w_issue;
  logic                       w_illegal;
  logic [N_UNITS-1:0]         w_done;

  assign w_opc  = iq_dat[OPC_BITS-1:0];
  assign w_dst  = iq_dat[DST_LSB  +: REG_FIELD_W];
  assign w_srca = iq_dat[SRCA_LSB +: REG_FIELD_W];
  assign w_srcb = iq_dat[SRCB_LSB +: REG_FIELD_W];

  // Decode: scanning downward leaves the lowest-index matching unit selected
  always_comb begin
    w_tgt_oh = '0;
    w_tgt_id = '0;
    w_hit    = 1'b0;
    for (int u = N_UNITS-1; u >= 0; u--) begin
      if (UNIT_OPC[u*OPC_BITS +: OPC_BITS] == w_opc) begin
        w_tgt_oh    = '0;
        w_tgt_oh[u] = 1'b1;
        w_tgt_id    = unit_id_t'(u);
        w_hit       = 1'b1;
      end
    end
  end

  assign w_tgt_busy    = |(w_tgt_oh & r_busy);
  assign w_tgt_serial  = |(w_tgt_oh & SERIAL);
  assign w_tgt_uses    = |(w_tgt_oh & USES_SRC);
  assign w_tgt_writes  = |(w_tgt_oh & WRITES_DST);
  assign w_any_busy    = |r_busy;
  assign w_serial_busy = |(r_busy & SERIAL);
  assign w_src_hazard  = w_tgt_uses & (w_a_pend | w_b_pend);
  assign w_dst_hazard  = w_tgt_writes & w_d_pend;

  // Completion is only honoured on units that are actually running
  assign w_done = u_dn & r_busy;

  assign w_issue   = ~rst & iq_ip & w_hit & ~w_tgt_busy & ~w_serial_busy
                   & ~(w_tgt_serial & w_any_busy) & ~w_src_hazard & ~w_dst_hazard;
  assign w_illegal = ~rst & iq_ip & ~w_hit;

  assign iq_pop    = w_issue | w_illegal;
  assign illegal   = w_illegal;
  assign u_en      = r_busy;
  assign busy      = w_any_busy;
  assign u_ins     = r_u_ins;
  assign issue_cnt = r_issue_cnt;
  assign stall_cnt = r_stall_cnt;

  // Unit occupancy: set on issue, cleared by that unit's done
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_done) | (w_issue ? w_tgt_oh : '0);
    end
  end

  // Latch the issued instruction into the target unit's slot
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      r_u_ins <= '0;
    end else begin
      for (int u = 0; u < N_UNITS; u++) begin
        if (w_issue && w_tgt_oh[u]) begin
          r_u_ins[u*INSTR_W +: INSTR_W] <= iq_dat;
        end
      end
    end
  end

  // Free-running issue and stall counters, wrapping at 2^32
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + 32'd1;
      end
      if (iq_ip && !iq_pop) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  gpr_scoreboard #(
    .N_UNITS (N_UNITS),
    .NUM_GPR (NUM_GPR)
  ) u_scoreboard (
    .clk          (cclk),
    .rst          (rst),
    .claim_en     (w_issue & w_tgt_writes),
    .claim_reg    (w_dst),
    .claim_unit   (w_tgt_id),
    .release_mask (w_done),
    .qry_a        (w_srca),
    .qry_b        (w_srcb),
    .qry_d        (w_dst),
    .a_pend       (w_a_pend),
    .b_pend       (w_b_pend),
    .d_pend       (w_d_pend),
    .u_gpr_we     (u_gpr_we),
    .u_gpr_dat    (u_gpr_dat),
    .gpr_we       (gpr_we),
    .gpr_dat      (gpr_dat)
  );

endmodule
`default_nettype wire

// File: tb/tb_exec_dispatch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module  : tb_exec_dispatch_unit                                      |
// | Brief   : Directed self-checking bench for exec_dispatch_unit.       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_exec_dispatch_unit;

  localparam int NU = 4;
  localparam int IW = 32;
  localparam int NG = 16;

  logic              cclk = 1'b0;
  logic              rst;
  logic              iq_ip;
  logic [IW-1:0]     iq_dat;
  logic              iq_pop;
  logic [NU-1:0]     u_en;
  logic [NU*IW-1:0]  u_ins;
  logic [NU-1:0]     u_dn;
  logic [NU*NG-1:0]  u_gpr_we;
  logic [NU*NG*32-1:0] u_gpr_dat;
  logic [NG-1:0]     gpr_we;
  logic [NG*32-1:0]  gpr_dat;
  logic              illegal;
  logic              busy;
  logic [31:0]       issue_cnt;
  logic [31:0]       stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 cclk = ~cclk;

  exec_dispatch_unit dut (
    .cclk      (cclk),
    .rst       (rst),
    .iq_ip     (iq_ip),
    .iq_dat    (iq_dat),
    .iq_pop    (iq_pop),
    .u_en      (u_en),
    .u_ins     (u_ins),
    .u_dn      (u_dn),
    .u_gpr_we  (u_gpr_we),
    .u_gpr_dat (u_gpr_dat),
    .gpr_we    (gpr_we),
    .gpr_dat   (gpr_dat),
    .illegal   (illegal),
    .busy      (busy),
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt)
  );

  // Build an instruction: {16'h0, srcB, srcA, dst, 1'b0, opc}
  function automatic logic [31:0] mk(logic [2:0] opc, logic [3:0] d, logic [3:0] a, logic [3:0] b);
    return {16'h0000, b, a, d, 1'b0, opc};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge cclk);
    #2;
  endtask

  task automatic set_wr(int u, int r, logic [31:0] d);
    u_gpr_we[u*NG + r] = 1'b1;
    u_gpr_dat[(u*NG + r)*32 +: 32] = d;
  endtask

  task automatic clr_wr();
    u_gpr_we  = '0;
    u_gpr_dat = '0;
  endtask

  initial begin
    rst = 1'b1; iq_ip = 1'b0; iq_dat = '0; u_dn = '0;
    u_gpr_we = '0; u_gpr_dat = '0;
    tick(); tick();

    // ---- reset state; pop/illegal forced low during reset
    iq_ip = 1'b1; iq_dat = 32'h0000_0000; #1;
    chk("rst_u_en", 64'(u_en), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_issue_cnt", 64'(issue_cnt), 64'h0);
    chk("rst_pop", 64'(iq_pop), 64'h0);
    chk("rst_illegal", 64'(illegal), 64'h0);
    tick();
    rst = 1'b0; iq_ip = 1'b0; iq_dat = '0;

    // ---- T1: ALU dst=3 src=1,2
    iq_ip = 1'b1; iq_dat = mk(3'b100, 4'd3, 4'd1, 4'd2); #1;
    chk("t1_pop_c0", 64'(iq_pop), 64'h1);
    chk("t1_ill_c0", 64'(illegal), 64'h0);
    tick();
    iq_ip = 1'b0;
    set_wr(0, 3, 32'hAAAA_0003); #1;
    chk("t1_u_en_c1", 64'(u_en), 64'h1);
    chk("t1_busy_c1", 64'(busy), 64'h1);
    chk("t1_issue_cnt", 64'(issue_cnt), 64'h1);
    chk("t1_u_ins0", 64'(u_ins[31:0]), 64'h0000_2134);
    chk("t1_gpr_we_pend", 64'(gpr_we), 64'h0008);
    chk("t1_gpr_dat3", 64'(gpr_dat[3*32 +: 32]), 64'hAAAA_0003);
    tick();
    u_dn = 4'b0001; #1;
    chk("t1_u_en_c2", 64'(u_en), 64'h1);
    chk("t1_gpr_we_done", 64'(gpr_we), 64'h0008);
    tick();
    u_dn = '0; #1;
    chk("t1_u_en_c3", 64'(u_en), 64'h0);
    chk("t1_gpr_we_rel", 64'(gpr_we), 64'h0000);
    clr_wr();

    // ---- T2: RAW on r3 between two ALU ops
    iq_ip = 1'b1; iq_dat = mk(3'b100, 4'd3, 4'd1, 4'd2); #1;
    chk("t2_pop_a0", 64'(iq_pop), 64'h1);
    tick();
    iq_dat = mk(3'b100, 4'd4, 4'd3, 4'd1); #1;
    chk("t2_pop_a1", 64'(iq_pop), 64'h0);
    tick();
    u_dn = 4'b0001; #1;
    chk("t2_pop_a2", 64'(iq_pop), 64'h0);
    tick();
    u_dn = '0; #1;
    chk("t2_pop_a3", 64'(iq_pop), 64'h1);
    chk("t2_stall_cnt", 64'(stall_cnt), 64'h2);
    chk("t2_issue_cnt_a3", 64'(issue_cnt), 64'h2);
    tick();
    iq_ip = 1'b0; #1;
    chk("t2_u_en_a4", 64'(u_en), 64'h1);
    chk("t2_u_ins0_b", 64'(u_ins[31:0]), 64'h0000_1344);
    chk("t2_issue_cnt_a4", 64'(issue_cnt), 64'h3);
    u_dn = 4'b0001;
    tick();
    u_dn = '0;

    // ---- T3: LSU dst=5 and independent ALU dst=6 run together
    iq_ip = 1'b1; iq_dat = mk(3'b010, 4'd5, 4'd0, 4'd0); #1;
    chk("t3_pop_lsu", 64'(iq_pop), 64'h1);
    tick();
    iq_dat = mk(3'b100, 4'd6, 4'd1, 4'd2); #1;
    chk("t3_pop_alu", 64'(iq_pop), 64'h1);
    tick();
    iq_ip = 1'b0;
    set_wr(2, 5, 32'h5555_0005);
    set_wr(0, 6, 32'h6666_0006);
    set_wr(0, 5, 32'hDEAD_BEEF); #1;
    chk("t3_u_en", 64'(u_en), 64'h5);
    chk("t3_u_ins2", 64'(u_ins[2*32 +: 32]), 64'h0000_0052);
    chk("t3_gpr_we", 64'(gpr_we), 64'h0060);
    chk("t3_gpr_dat5", 64'(gpr_dat[5*32 +: 32]), 64'h5555_0005);
    chk("t3_gpr_dat6", 64'(gpr_dat[6*32 +: 32]), 64'h6666_0006);
    u_dn = 4'b0101;
    tick();
    u_dn = '0; clr_wr(); #1;
    chk("t3_idle", 64'(u_en), 64'h0);
    chk("t3_issue_cnt", 64'(issue_cnt), 64'h5);

    // ---- T4: PFCU serialisation
    iq_ip = 1'b1; iq_dat = mk(3'b100, 4'd7, 4'd1, 4'd2); #1;
    chk("t4_pop_d0", 64'(iq_pop), 64'h1);
    tick();
    iq_dat = mk(3'b110, 4'd0, 4'd0, 4'd0); #1;
    chk("t4_pop_d1", 64'(iq_pop), 64'h0);
    tick();
    u_dn = 4'b0001; #1;
    chk("t4_pop_d2", 64'(iq_pop), 64'h0);
    tick();
    u_dn = '0; #1;
    chk("t4_pop_d3", 64'(iq_pop), 64'h1);
    tick();
    iq_dat = mk(3'b100, 4'd8, 4'd1, 4'd2); #1;
    chk("t4_u_en_d4", 64'(u_en), 64'h2);
    chk("t4_pop_d4", 64'(iq_pop), 64'h0);
    tick();
    u_dn = 4'b0010; #1;
    chk("t4_pop_d5", 64'(iq_pop), 64'h0);
    tick();
    u_dn = '0; #1;
    chk("t4_pop_d6", 64'(iq_pop), 64'h1);
    tick();
    iq_ip = 1'b0; #1;
    chk("t4_u_en_d7", 64'(u_en), 64'h1);
    chk("t4_issue_cnt", 64'(issue_cnt), 64'h8);
    chk("t4_stall_cnt", 64'(stall_cnt), 64'h6);
    u_dn = 4'b0001;
    tick();
    u_dn = '0;

    // ---- T5: illegal opcode and unowned writes
    iq_ip = 1'b1; iq_dat = mk(3'b000, 4'd9, 4'd0, 4'd0); #1;
    chk("t5_illegal", 64'(illegal), 64'h1);
    chk("t5_pop", 64'(iq_pop), 64'h1);
    tick();
    iq_ip = 1'b0;
    set_wr(3, 9, 32'h9999_0009);
    set_wr(0, 10, 32'hAAAA_000A); #1;
    chk("t5_illegal_off", 64'(illegal), 64'h0);
    chk("t5_issue_cnt", 64'(issue_cnt), 64'h8);
    chk("t5_u_en", 64'(u_en), 64'h0);
    chk("t5_gpr_we_unowned", 64'(gpr_we), 64'h0000);
    clr_wr();

    // ---- T6: asynchronous reset with two units in flight
    iq_ip = 1'b1; iq_dat = mk(3'b010, 4'd11, 4'd0, 4'd0);
    tick();
    iq_dat = mk(3'b100, 4'd12, 4'd1, 4'd2);
    tick();
    iq_ip = 1'b0;
    set_wr(2, 11, 32'hBBBB_000B); #1;
    chk("t6_u_en_pre", 64'(u_en), 64'h5);
    chk("t6_gpr_we_pre", 64'(gpr_we), 64'h0800);
    rst = 1'b1; #1;
    chk("t6_u_en_rst", 64'(u_en), 64'h0);
    chk("t6_busy_rst", 64'(busy), 64'h0);
    chk("t6_gpr_we_rst", 64'(gpr_we), 64'h0000);
    chk("t6_issue_cnt_rst", 64'(issue_cnt), 64'h0);
    chk("t6_stall_cnt_rst", 64'(stall_cnt), 64'h0);
    chk("t6_u_ins_rst", 64'(u_ins[2*32 +: 32]), 64'h0);
    tick();
    rst = 1'b0;
    set_wr(2, 11, 32'hBBBB_000B); #1;
    chk("t6_gpr_we_post", 64'(gpr_we), 64'h0000);
    clr_wr();
    iq_ip = 1'b1; iq_dat = mk(3'b100, 4'd12, 4'd1, 4'd2); #1;
    chk("t6_pop_post", 64'(iq_pop), 64'h1);
    tick();
    iq_ip = 1'b0; #1;
    chk("t6_u_en_post", 64'(u_en), 64'h1);
    chk("t6_issue_cnt_post", 64'(issue_cnt), 64'h1);
    chk("t6_u_ins0_post", 64'(u_ins[31:0]), 64'h0000_21C4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exec_dispatch_unit.md
Name: exec_dispatch_unit

Overview:
Parametrised in-order dispatcher between the instruction queue and N execution units. Decodes each queued instruction's opcode class and issues it to the matching unit. Unlike a single-unit-at-a-time selector, it keeps several units in flight concurrently, guarded by a GPR scoreboard. It arbitrates per-register GPR write ports by ownership and serialises program-flow instructions.

Parameters:
N_UNITS, 4, number of execution units
INSTR_W, 32, instruction width
OPC_BITS, 3, opcode class field width, bits[OPC_BITS-1:0]
NUM_GPR, 16, general purpose register count
UNIT_OPC, {3'b001,3'b010,3'b110,3'b100}, packed opcode per unit, unit0 in LSBs (unit0 ALU, unit1 PFCU, unit2 LSU, unit3 spare)
WRITES_DST, 4'b0101, units that claim dst register
USES_SRC, 4'b0101, units that read srcA/srcB
SERIAL, 4'b0010, units that issue only when all units idle and block issue while busy

Ports:
cclk  in  1  core clock
rst  in  1  asynchronous active-high reset
iq_ip  in  1  instruction queue non-empty
iq_dat  in  INSTR_W  head instruction
iq_pop  out  1  pop head (combinational, same cycle as issue)
u_en  out  N_UNITS  per-unit enable, level
u_ins  out  N_UNITS*INSTR_W  latched instruction per unit
u_dn  in  N_UNITS  per-unit done
u_gpr_we  in  N_UNITS*NUM_GPR  per-unit register write enables
u_gpr_dat  in  N_UNITS*NUM_GPR*32  per-unit register write data
gpr_we  out  NUM_GPR  to GPR file
gpr_dat  out  NUM_GPR*32  to GPR file
illegal  out  1  one-cycle pulse on undecodable opcode
busy  out  1  any unit busy
issue_cnt  out  32  issued instructions, wraps
stall_cnt  out  32  cycles with iq_ip=1 and no pop, wraps

Behaviour:
- Fields: dst=bits[7:4], srcA=bits[11:8], srcB=bits[15:12].
- Decode: the lowest-index unit whose UNIT_OPC matches is the target.
- No match: iq_pop=1, illegal=1 for that cycle, no issue, issue_cnt unchanged.
- Issue when all of the following hold:
  - iq_ip=1 and target busy_r[u]=0;
  - no SERIAL unit busy;
  - if target is SERIAL, all units idle;
  - if USES_SRC[u], srcA and srcB are not pending;
  - if WRITES_DST[u], dst is not pending.
- On issue, iq_pop=1 that cycle. At the next edge: u_ins[u]<=iq_dat, busy_r[u]<=1, and if WRITES_DST[u] then pending[dst]<=1 and owner[dst]<=u. issue_cnt increments.
- u_en[u]=busy_r[u], so latency is 1 cycle from pop to enable.
- Completion: u_dn[u]=1 while busy_r[u]=1 clears busy_r[u] and all pending[r] with owner[r]=u at that edge. u_dn on an idle unit is ignored.
- A unit completing in cycle t cannot be reissued before t+1, since busy is still set at t. A dependent instruction waiting on the released register issues at t+1.
- Issue to unit A and completion of unit B in the same cycle are both applied. If dst of the new issue equals a register released by B, the new claim wins.
- GPR writes:
  - gpr_we[r] = pending[r] & u_gpr_we[owner[r]][r], with gpr_dat[r] from the owner.
  - Non-claiming units (e.g. LSU loads targeting registers outside dst) must claim via dst. Writes to unowned registers are dropped.
  - Writes in the completion cycle are still forwarded, because pending clears only at that edge.
- Reset (async, mid-operation included): busy_r=0, pending=0, owner=0, u_ins=0, counters=0. All outputs are 0, including iq_pop, illegal and gpr_we, which are forced low while rst=1. In-flight units see u_en drop immediately.
- Counters wrap at 2^32 with no saturation.

Decomposition:
- Package dispatch_pkg: field offset constants (DST_LSB, SRCA_LSB, SRCB_LSB), opcode class constants (OPC_ALU=3'b100, OPC_PFCU=3'b110, OPC_LSU=3'b010), unit_id_t typedef.
- Sub-module gpr_scoreboard: pending/owner arrays, claim/release ports, hazard query, per-register write mux.
- Top level holds decode, issue logic, unit state and counters.

Test Plan:
- ALU instr (bits[2:0]=100, dst=3, src=1,2) with u_dn asserted 2 cycles after u_en → pop in cycle 0; u_en[0] high cycles 1-2; pending[3] set then cleared; issue_cnt=1.
- ALU writes r3 and a second ALU instr reads r3 → second pop occurs exactly the cycle after first u_dn; stall_cnt counts the waiting cycles.
- LSU instr (dst=5) followed by independent ALU instr (dst=6, src=1,2) → both busy concurrently; u_gpr_we for r5 from LSU and r6 from ALU both reach gpr_we in the same cycle.
- PFCU instr (110) with ALU busy → no pop until the ALU is done; while PFCU is busy, a queued ALU instr stalls; ALU issues the cycle after PFCU u_dn.
- Opcode 3'b000 → illegal pulses for 1 cycle, pop=1, issue_cnt unchanged. A unit asserting u_gpr_we on an unowned register → gpr_we stays 0.
- Assert rst while two units are busy → u_en, busy and pending are 0 immediately, counters are 0; the first instruction after release issues normally.
